mdio_peripheral: RTL and testbench

MDIO_PERIPHERAL -- requirements
Module: mdio_peripheral

---
 rtl/mdio_peripheral.sv | 250 +++++++++++++++++++++++++
 tb/tb_mdio_peripheral.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral.sv
// MDIO (clause 22) management peripheral: decodes controller frames on MDC rises,
// issues register-file write/read strobes and serialises read data on MDC falls.
module mdio_peripheral #(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] MEM_RD_DATA,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_HDR   = 3'd2,
        S_WR    = 3'd3,
        S_RD    = 3'd4,
        S_SKIP  = 3'd5
    } state_t;

    localparam logic [1:0] OP_WR       = 2'b01;
    localparam logic [1:0] OP_RD       = 2'b10;
    localparam logic [5:0] BIT_HDR_END = 6'd14;
    localparam logic [5:0] BIT_TA1     = 6'd15;
    localparam logic [5:0] BIT_D15     = 6'd16;
    localparam logic [5:0] BIT_D0      = 6'd31;
    localparam logic [5:0] BIT_LAST    = 6'd32;

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [5:0]  cnt_q, cnt_d;
    logic [10:0] hdr_q, hdr_d;
    logic [14:0] wr_sr_q, wr_sr_d;
    logic [15:0] rd_sr_q, rd_sr_d;
    logic        rd_cap_q, rd_cap_d;
    logic        mdio_in_q, mdio_in_d;
    logic        mdio_in_oe_q, mdio_in_oe_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_stb_q, wr_stb_d;
    logic        rd_stb_q, rd_stb_d;
    logic        frame_err_q, frame_err_d;

    logic        mdc_rise_s;
    logic        mdc_fall_s;
    logic [5:0]  bit_num_s;
    logic [11:0] hdr_full_s;
    logic [1:0]  op_s;
    logic [4:0]  phy_s;
    logic [4:0]  regad_s;

    assign mdc_rise_s = MDC & ~mdc_q;
    assign mdc_fall_s = ~MDC & mdc_q;
    assign bit_num_s  = cnt_q + 6'd1;
    // Bits 3..14 of the frame once the current rise's bit is appended.
    assign hdr_full_s = {hdr_q, MDIO_OUT};
    assign op_s       = hdr_full_s[11:10];
    assign phy_s      = hdr_full_s[9:5];
    assign regad_s    = hdr_full_s[4:0];

    // Next-state and output computation for the frame decoder.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        wr_sr_d     = wr_sr_q;
        rd_cap_d    = rd_stb_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == S_RD) begin
            mdio_in_d    = mdio_in_q;
            mdio_in_oe_d = mdio_in_oe_q;
        end else begin
            mdio_in_d    = 1'b0;
            mdio_in_oe_d = 1'b0;
        end

        // Register data arrives the clk after RD_STB; the first data fall is much later.
        if (rd_cap_q) begin
            rd_sr_d = MEM_RD_DATA;
        end else begin
            rd_sr_d = rd_sr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (mdc_rise_s && MDIO_OE && !MDIO_OUT) begin
                    state_d = S_START;
                    cnt_d   = 6'd1;
                end else begin
                    cnt_d   = 6'd0;
                end
            end
            S_START: begin
                if (mdc_rise_s) begin
                    if (MDIO_OUT) begin
                        state_d = S_HDR;
                        cnt_d   = bit_num_s;
                    end else begin
                        state_d     = S_IDLE;
                        cnt_d       = 6'd0;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_HDR: begin
                if (mdc_rise_s) begin
                    cnt_d = bit_num_s;
                    hdr_d = hdr_full_s[10:0];
                    if (bit_num_s == BIT_HDR_END) begin
                        if (op_s == OP_WR || op_s == OP_RD) begin
                            if (phy_s == PHY_ADDR) begin
                                if (op_s == OP_WR) begin
                                    state_d = S_WR;
                                end else begin
                                    state_d  = S_RD;
                                    rd_stb_d = 1'b1;
                                    addr_d   = regad_s;
                                end
                            end else begin
                                state_d = S_SKIP;
                            end
                        end else begin
                            state_d     = S_SKIP;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_HDR;
                    end
                end else begin
                    state_d = S_HDR;
                end
            end
            S_WR: begin
                if (mdc_rise_s) begin
                    wr_sr_d = {wr_sr_q[13:0], MDIO_OUT};
                    if (bit_num_s == BIT_LAST) begin
                        addr_d    = hdr_q[4:0];
                        wr_data_d = {wr_sr_q, MDIO_OUT};
                        wr_stb_d  = 1'b1;
                        state_d   = S_IDLE;
                        cnt_d     = 6'd0;
                    end else begin
                        cnt_d     = bit_num_s;
                    end
                end else begin
                    state_d = S_WR;
                end
            end
            S_RD: begin
                // Read data changes on MDC falls so the controller samples it on the next rise.
                if (mdc_fall_s) begin
                    if (cnt_q == BIT_TA1) begin
                        mdio_in_oe_d = 1'b1;
                        mdio_in_d    = 1'b0;
                    end else if (cnt_q >= BIT_D15 && cnt_q <= BIT_D0) begin
                        mdio_in_d = rd_sr_q[15];
                        rd_sr_d   = {rd_sr_q[14:0], 1'b0};
                    end else if (cnt_q == BIT_LAST) begin
                        mdio_in_oe_d = 1'b0;
                        mdio_in_d    = 1'b0;
                        state_d      = S_IDLE;
                        cnt_d        = 6'd0;
                    end else begin
                        state_d = S_RD;
                    end
                end else if (mdc_rise_s) begin
                    cnt_d = bit_num_s;
                end else begin
                    state_d = S_RD;
                end
            end
            S_SKIP: begin
                if (mdc_rise_s) begin
                    if (bit_num_s == BIT_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d   = bit_num_s;
                    end
                end else begin
                    state_d = S_SKIP;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and registered-output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mdc_q        <= 1'b0;
            cnt_q        <= 6'd0;
            hdr_q        <= 11'd0;
            wr_sr_q      <= 15'd0;
            rd_sr_q      <= 16'd0;
            rd_cap_q     <= 1'b0;
            mdio_in_q    <= 1'b0;
            mdio_in_oe_q <= 1'b0;
            addr_q       <= 5'd0;
            wr_data_q    <= 16'd0;
            wr_stb_q     <= 1'b0;
            rd_stb_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mdc_q        <= MDC;
            cnt_q        <= cnt_d;
            hdr_q        <= hdr_d;
            wr_sr_q      <= wr_sr_d;
            rd_sr_q      <= rd_sr_d;
            rd_cap_q     <= rd_cap_d;
            mdio_in_q    <= mdio_in_d;
            mdio_in_oe_q <= mdio_in_oe_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            wr_stb_q     <= wr_stb_d;
            rd_stb_q     <= rd_stb_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign MDIO_IN    = mdio_in_q;
    assign MDIO_IN_OE = mdio_in_oe_q;
    assign ADDR       = addr_q;
    assign WR_DATA    = wr_data_q;
    assign WR_STB     = wr_stb_q;
    assign RD_STB     = rd_stb_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// Directed bench for mdio_peripheral: a frame-level model predicts strobes and the
// read-drive window; one compare process checks them every clk.
module tb_mdio_peripheral;

    localparam logic [4:0] PHY = 5'd0;
    localparam logic [1:0] EV_WR  = 2'd1;
    localparam logic [1:0] EV_RD  = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDC;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic        MDIO_IN;
    logic        MDIO_IN_OE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic [15:0] MEM_RD_DATA;
    logic        FRAME_ERR;

    logic [15:0] mem [0:31];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        settle   = 1'b0;
    logic        exp_oe   = 1'b0;
    logic        exp_in   = 1'b0;
    ev_t         exp_q[$];
    logic [16:0] last_rd;

    always #5 clk = ~clk;

    assign MEM_RD_DATA = mem[ADDR];

    mdio_peripheral #(.PHY_ADDR(PHY)) dut (
        .clk        (clk),
        .reset      (reset),
        .MDC        (MDC),
        .MDIO_OUT   (MDIO_OUT),
        .MDIO_OE    (MDIO_OE),
        .MDIO_IN    (MDIO_IN),
        .MDIO_IN_OE (MDIO_IN_OE),
        .ADDR       (ADDR),
        .WR_DATA    (WR_DATA),
        .WR_STB     (WR_STB),
        .RD_STB     (RD_STB),
        .MEM_RD_DATA(MEM_RD_DATA),
        .FRAME_ERR  (FRAME_ERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare process: strobes against the expected-event queue, read drive against the model.
    always @(negedge clk) begin
        ev_t        e;
        logic [1:0] k;
        if (WR_STB === 1'b1 || RD_STB === 1'b1 || FRAME_ERR === 1'b1) begin
            k = WR_STB ? EV_WR : (RD_STB ? EV_RD : EV_ERR);
            check("single_event", 32'(WR_STB) + 32'(RD_STB) + 32'(FRAME_ERR), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, k}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {30'd0, k}, {30'd0, e.kind});
                if (k == EV_WR) begin
                    check("wr_addr", {27'd0, ADDR}, {27'd0, e.addr});
                    check("wr_data", {16'd0, WR_DATA}, {16'd0, e.data});
                end else if (k == EV_RD) begin
                    check("rd_addr", {27'd0, ADDR}, {27'd0, e.addr});
                end
            end
        end
        if (settle) begin
            check("mdio_in_oe", {31'd0, MDIO_IN_OE}, {31'd0, exp_oe});
            check("mdio_in", {31'd0, MDIO_IN}, {31'd0, exp_oe ? exp_in : 1'b0});
        end
    end

    // One MDC period: data set while MDC low, rise, then fall (read-drive model updated at the fall).
    task automatic drive_bit(input logic b, input logic oe, input int n, input logic rd,
                             input logic [15:0] rdata, output logic sampled);
        MDIO_OUT = b;
        MDIO_OE  = oe;
        repeat (3) @(posedge clk);
        #1;
        sampled = MDIO_IN;
        MDC     = 1'b1;
        settle  = 1'b0;
        repeat (2) @(posedge clk);
        #1 settle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        MDC    = 1'b0;
        settle = 1'b0;
        if (rd) begin
            if (n == 15) begin
                exp_oe = 1'b1;
                exp_in = 1'b0;
            end else if (n >= 16 && n <= 31) begin
                exp_oe = 1'b1;
                exp_in = rdata[31 - n];
            end else if (n == 32) begin
                exp_oe = 1'b0;
                exp_in = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        #1 settle = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits);
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic        resp_rd;
        logic        s;
        logic [16:0] rd_bits;
        ev_t         e;
        op      = w[29:28];
        phy     = w[27:23];
        rg      = w[22:18];
        resp_rd = (op == 2'b10) && (phy == PHY);
        if (nbits >= 14 && (op == 2'b00 || op == 2'b11)) begin
            e = '{kind: EV_ERR, addr: 5'd0, data: 16'd0};
            exp_q.push_back(e);
        end else if (nbits >= 14 && resp_rd) begin
            e = '{kind: EV_RD, addr: rg, data: 16'd0};
            exp_q.push_back(e);
        end else if (nbits >= 32 && op == 2'b01 && phy == PHY) begin
            e = '{kind: EV_WR, addr: rg, data: w[15:0]};
            exp_q.push_back(e);
        end
        rd_bits = 17'd0;
        for (int i = 1; i <= nbits; i++) begin
            drive_bit(w[32 - i], !(op == 2'b10 && i >= 15), i, resp_rd, mem[rg], s);
            if (i >= 16) begin
                rd_bits = {rd_bits[15:0], s};
            end
        end
        last_rd = rd_bits;
        MDIO_OE = 1'b0;
    endtask

    task automatic end_frame(input string name);
        repeat (4) @(posedge clk);
        #1;
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic s;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 16'hDEAD;
        end
        mem[3]   = 16'h1234;
        mem[7]   = 16'hA5C3;
        reset    = 1'b1;
        MDC      = 1'b0;
        MDIO_OUT = 1'b1;
        MDIO_OE  = 1'b0;
        last_rd  = 17'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdio_in", {31'd0, MDIO_IN}, 32'd0);
        check("rst_mdio_in_oe", {31'd0, MDIO_IN_OE}, 32'd0);
        check("rst_addr", {27'd0, ADDR}, 32'd0);
        check("rst_wr_data", {16'd0, WR_DATA}, 32'd0);
        check("rst_wr_stb", {31'd0, WR_STB}, 32'd0);
        check("rst_rd_stb", {31'd0, RD_STB}, 32'd0);
        check("rst_frame_err", {31'd0, FRAME_ERR}, 32'd0);
        reset  = 1'b0;
        settle = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Plain write to register 2.
        send_frame(32'h500AABCD, 32);
        end_frame("write_events");
        check("write_addr_lit", {27'd0, ADDR}, 32'd2);
        check("write_data_lit", {16'd0, WR_DATA}, 32'h0000ABCD);

        // Read of register 3: turnaround zero then the data word.
        send_frame(32'h600C0000, 32);
        end_frame("read_events");
        check("read_sample_lit", {15'd0, last_rd}, 32'h00001234);
        check("read_addr_lit", {27'd0, ADDR}, 32'd3);
        check("read_wr_data_hold", {16'd0, WR_DATA}, 32'h0000ABCD);

        // Read of register 7.
        send_frame(32'h601C0000, 32);
        end_frame("read7_events");
        check("read7_sample_lit", {15'd0, last_rd}, 32'h0000A5C3);

        // PHY address mismatch, then a valid write is accepted.
        send_frame(32'h508AABCD, 32);
        end_frame("mismatch_events");
        check("mismatch_addr_hold", {27'd0, ADDR}, 32'd7);
        send_frame(32'h50121111, 32);
        end_frame("after_mismatch_events");
        check("after_mismatch_addr_lit", {27'd0, ADDR}, 32'd4);
        check("after_mismatch_data_lit", {16'd0, WR_DATA}, 32'h00001111);

        // Bad opcode pulses FRAME_ERR and skips the remaining bits.
        send_frame(32'h700A0000, 32);
        end_frame("bad_op_events");

        // Malformed start: second bit zero.
        exp_q.push_back('{kind: EV_ERR, addr: 5'd0, data: 16'd0});
        drive_bit(1'b0, 1'b1, 0, 1'b0, 16'd0, s);
        drive_bit(1'b0, 1'b1, 0, 1'b0, 16'd0, s);
        MDIO_OE = 1'b0;
        end_frame("bad_start_events");

        // Preamble of ones then a write.
        for (int i = 0; i < 32; i++) begin
            drive_bit(1'b1, 1'b1, 0, 1'b0, 16'd0, s);
        end
        send_frame(32'h500A0001, 32);
        end_frame("preamble_events");
        check("preamble_addr_lit", {27'd0, ADDR}, 32'd2);
        check("preamble_data_lit", {16'd0, WR_DATA}, 32'h00000001);

        // Reset in the middle of a read data phase.
        send_frame(32'h600C0000, 20);
        check("pre_reset_oe_lit", {31'd0, MDIO_IN_OE}, 32'd1);
        settle = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_oe = 1'b0;
        exp_in = 1'b0;
        settle = 1'b1;
        @(negedge clk);
        check("reset_abort_oe_lit", {31'd0, MDIO_IN_OE}, 32'd0);
        end_frame("reset_abort_events");
        send_frame(32'h500A5555, 32);
        end_frame("post_reset_events");
        check("post_reset_data_lit", {16'd0, WR_DATA}, 32'h00005555);
        check("post_reset_addr_lit", {27'd0, ADDR}, 32'd2);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
